alu_pipe_hs: RTL

- Parametrised 3-stage pipelined ALU; next generation of the team's flag-producing ALU.
- Adds: valid/ready handshake with backpressure, 4-bit opcode space (shifts, carry-chained ADC/SBC, INC/DEC), and an internal carry flag for multi-word arithmetic.
- Sits between the instruction-issue logic and the writeback/flag register file of the datapath.

---
 rtl/alu_pipe_hs.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: three-stage pipelined ALU with valid/ready handshake.
//
//   S1  registers a / b / opcode on an accepted transfer
//   S2  executes the operation, registers result/c/v and updates the
//       internal carry flag cf used by ADC/SBC
//   S3  registers result, c, v and derives z/n from the S2 result
//
// A stall (out_valid && !out_ready) freezes every stage and cf together,
// so the pipe never loses or duplicates an operation. ADC/SBC read cf
// while it already holds the carry of the immediately preceding op, so
// carry chains run back-to-back without bubbles.
//
// Build option: define ALU_SAT_EN to make opcode 15 a signed saturating
// add. Without it, opcode 15 is reserved and yields r=0, c=0, v=0 and
// clears cf.

module alu_pipe_hs #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOTA  = 4'd5,
        OP_NOTB  = 4'd6,
        OP_ADC   = 4'd7,
        OP_SBC   = 4'd8,
        OP_SHL   = 4'd9,
        OP_SHR   = 4'd10,
        OP_SAR   = 4'd11,
        OP_INC   = 4'd12,
        OP_DEC   = 4'd13,
        OP_PASSB = 4'd14,
        OP_SAT   = 4'd15
    } opcode_e;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ONE_W   = {{WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    opcode_e          s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_c;
    logic             s2_v;

    logic             cf;

    // ------------------------------------------------------------------
    // S2 execute datapath (all arithmetic WIDTH+1 bits wide)
    // ------------------------------------------------------------------
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     adc_w;
    logic [WIDTH:0]     sbc_w;
    logic [WIDTH:0]     inc_w;
    logic [WIDTH:0]     dec_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic signed [WIDTH:0] sar_w;
    logic               a_msb;
    logic               b_msb;
    logic               add_ovf;
    logic               sub_ovf;
    logic               adc_ovf;
    logic               sbc_ovf;

    // Upper bits of b are deliberately ignored as a shift amount.
    assign sh    = s1_b[SHW-1:0];
    assign a_msb = s1_a[WIDTH-1];
    assign b_msb = s1_b[WIDTH-1];

    assign add_w = {1'b0, s1_a} + {1'b0, s1_b};
    assign sub_w = {1'b0, s1_a} - {1'b0, s1_b};
    assign adc_w = add_w + {{WIDTH{1'b0}}, cf};
    assign sbc_w = sub_w - {{WIDTH{1'b0}}, cf};
    assign inc_w = {1'b0, s1_a} + ONE_W;
    assign dec_w = {1'b0, s1_a} - ONE_W;

    // Shifts keep one guard bit so the last bit shifted out lands in a
    // fixed position: bit WIDTH for left shifts, bit 0 for right shifts.
    // With a zero amount the guard bit is 0, which gives c=0 for free.
    assign shl_w = {1'b0, s1_a} << sh;
    assign shr_w = {s1_a, 1'b0} >> sh;
    assign sar_w = $signed({s1_a, 1'b0}) >>> sh;

    // Addition overflows when both operands share a sign the result lacks;
    // subtraction when the operands differ in sign and the result does
    // not follow a. The carry/borrow-in does not change either rule.
    assign add_ovf = (a_msb == b_msb) && (add_w[WIDTH-1] != a_msb);
    assign adc_ovf = (a_msb == b_msb) && (adc_w[WIDTH-1] != a_msb);
    assign sub_ovf = (a_msb != b_msb) && (sub_w[WIDTH-1] != a_msb);
    assign sbc_ovf = (a_msb != b_msb) && (sbc_w[WIDTH-1] != a_msb);

    logic [WIDTH-1:0] ex_r;
    logic             ex_c;
    logic             ex_v;

    // Select result, carry and overflow of the op sitting in S1.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; without
        // them a missing case arm would infer a latch.
        ex_r = '0;
        ex_c = 1'b0;
        ex_v = 1'b0;
        unique case (s1_op)
            OP_ADD: begin
                ex_r = add_w[WIDTH-1:0];
                ex_c = add_w[WIDTH];
                ex_v = add_ovf;
            end
            OP_SUB: begin
                ex_r = sub_w[WIDTH-1:0];
                ex_c = sub_w[WIDTH];
                ex_v = sub_ovf;
            end
            OP_AND:   ex_r = s1_a & s1_b;
            OP_OR:    ex_r = s1_a | s1_b;
            OP_XOR:   ex_r = s1_a ^ s1_b;
            OP_NOTA:  ex_r = ~s1_a;
            OP_NOTB:  ex_r = ~s1_b;
            OP_PASSB: ex_r = s1_b;
            OP_ADC: begin
                ex_r = adc_w[WIDTH-1:0];
                ex_c = adc_w[WIDTH];
                ex_v = adc_ovf;
            end
            OP_SBC: begin
                ex_r = sbc_w[WIDTH-1:0];
                ex_c = sbc_w[WIDTH];
                ex_v = sbc_ovf;
            end
            OP_SHL: begin
                ex_r = shl_w[WIDTH-1:0];
                ex_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                ex_r = shr_w[WIDTH:1];
                ex_c = shr_w[0];
            end
            OP_SAR: begin
                ex_r = sar_w[WIDTH:1];
                ex_c = sar_w[0];
            end
            OP_INC: begin
                ex_r = inc_w[WIDTH-1:0];
                ex_c = inc_w[WIDTH];
                ex_v = (s1_a == MAX_POS);
            end
            OP_DEC: begin
                ex_r = dec_w[WIDTH-1:0];
                ex_c = dec_w[WIDTH];
                ex_v = (s1_a == MIN_NEG);
            end
`ifdef ALU_SAT_EN
            OP_SAT: begin
                ex_r = add_ovf ? (a_msb ? MIN_NEG : MAX_POS) : add_w[WIDTH-1:0];
                ex_c = add_w[WIDTH];
                ex_v = add_ovf;
            end
`else
            OP_SAT: begin
                ex_r = '0;
                ex_c = 1'b0;
                ex_v = 1'b0;
            end
`endif
            default: begin
                ex_r = '0;
                ex_c = 1'b0;
                ex_v = 1'b0;
            end
        endcase
    end

    // S1: capture an accepted operation; a missing transfer leaves a bubble.
    always_ff @(posedge clk) begin
        // NOTE: operand registers are reset too, because a reset must leave
        // no trace of discarded in-flight operations anywhere in the pipe.
        if (rst) begin
            // NOTE: non-blocking assignments keep every stage sampling the
            // pre-edge value of its predecessor.
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= opcode_e'(opcode);
            end
        end
    end

    // S2: register the executed op and move its carry into cf.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_c      <= 1'b0;
            s2_v      <= 1'b0;
            cf        <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= ex_r;
                s2_c      <= ex_c;
                s2_v      <= ex_v;
                cf        <= ex_c;
            end
        end
    end

    // S3: present result and flags; they hold while no new result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= s2_result;
                z      <= (s2_result == '0);
                n      <= s2_result[WIDTH-1];
                c      <= s2_c;
                v      <= s2_v;
            end
        end
    end

endmodule
